com_pingpong_buf_ctrl: RTL and testbench

COM_PINGPONG_BUF_CTRL -- requirements
Module: com_pingpong_buf_ctrl

---
 rtl/com_pingpong_buf_ctrl.sv | 97 +++++++++
 tb/tb_com_pingpong_buf_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/com_pingpong_buf_ctrl.sv
// Two-bank ping-pong buffer controller: a writer fills banks alternately and
// commits them; a reader drains committed banks in the same order.
module com_pingpong_buf_ctrl #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [ADDR_BIT-2:0]   rd_addr,
  input  logic                  rd_done,
  output logic                  rd_avail,
  output logic [ADDR_BIT-1:0]   rd_len,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic [1:0]            banks_full,
  output logic                  ram_en_a,
  output logic                  ram_we_a,
  output logic [ADDR_BIT-1:0]   ram_addr_a,
  output logic [WIDTH-1:0]      ram_di_a,
  output logic                  ram_en_b,
  output logic                  ram_we_b,
  output logic [ADDR_BIT-1:0]   ram_addr_b,
  input  logic [WIDTH-1:0]      ram_dout_b
);

  localparam int OW = ADDR_BIT - 1;
  localparam logic [OW-1:0] WCNT_MAX = '1;

  logic                wb;
  logic                rb;
  logic [OW-1:0]       wcnt;
  logic [1:0]          full;
  logic [ADDR_BIT-1:0] len [2];

  logic wr_acc;
  logic commit;
  logic rd_acc;
  logic rd_rel;

  assign wr_ready = !full[wb];
  // Accesses are suppressed in the reset cycle so nothing reaches the RAM.
  assign wr_acc   = wr_valid & wr_ready & !rst;
  assign commit   = wr_acc & (wr_last | (wcnt == WCNT_MAX));

  assign rd_avail = full[rb];
  assign rd_len   = len[rb];
  assign rd_acc   = rd_req & rd_avail & !rst;
  assign rd_rel   = rd_done & rd_avail & !rst;

  assign ram_en_a   = wr_acc;
  assign ram_we_a   = wr_acc;
  assign ram_addr_a = {wb, wcnt};
  assign ram_di_a   = wr_data;

  assign ram_en_b   = rd_acc;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = {rb, rd_addr};
  assign rd_data    = ram_dout_b;

  assign banks_full = {1'b0, full[0]} + {1'b0, full[1]};

  // Commit and release can coincide; commit needs full[wb]=0 and release
  // needs full[rb]=1, so they always target different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb            <= 1'b0;
      rb            <= 1'b0;
      wcnt          <= '0;
      full          <= '0;
      len[0]        <= '0;
      len[1]        <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_acc;
      if (wr_acc) begin
        if (commit) begin
          full[wb] <= 1'b1;
          len[wb]  <= {1'b0, wcnt} + 1'b1;
          wcnt     <= '0;
          wb       <= ~wb;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (rd_rel) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

endmodule

// File: tb/tb_com_pingpong_buf_ctrl.sv
// Directed bench for com_pingpong_buf_ctrl with ADDR_BIT=4 (bank depth 8)
// and a behavioural 1-cycle-latency RAM attached to the controller ports.
module tb_com_pingpong_buf_ctrl;

  localparam int W  = 8;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_req;
  logic [AB-2:0] rd_addr;
  logic          rd_done;
  logic          rd_avail;
  logic [AB-1:0] rd_len;
  logic [W-1:0]  rd_data;
  logic          rd_data_valid;
  logic [1:0]    banks_full;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AB-1:0] ram_addr_a, ram_addr_b;
  logic [W-1:0]  ram_di_a, ram_dout_b;

  logic [W-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  com_pingpong_buf_ctrl #(.WIDTH(W), .ADDR_BIT(AB)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_avail(rd_avail), .rd_len(rd_len), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .banks_full(banks_full),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_di_a(ram_di_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_di_a;
    if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic idle();
    wr_valid = 0; wr_data = '0; wr_last = 0;
    rd_req = 0; rd_addr = '0; rd_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); end
    checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL reset_rd_avail: got %b exp 0", rd_avail); end
    checks++; if (rd_len !== 4'd0) begin errors++; $display("FAIL reset_rd_len: got %0d exp 0", rd_len); end
    checks++; if (banks_full !== 2'd0) begin errors++; $display("FAIL reset_banks_full: got %0d exp 0", banks_full); end
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_data_valid: got %b exp 0", rd_data_valid); end
    checks++; if ({ram_en_a, ram_en_b, ram_we_b} !== 3'b000) begin errors++; $display("FAIL reset_ram_en: got %b exp 000", {ram_en_a, ram_en_b, ram_we_b}); end
    rst = 0;
  endtask

  // Three words with wr_last on the third commit bank 0 with length 3.
  task automatic test_short_fill();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_valid = 1; wr_data = W'(8'hA0 + i); wr_last = (i == 2); #1;
      checks++; if ({ram_en_a, ram_we_a} !== 2'b11) begin errors++; $display("FAIL fill_en[%0d]: got %b exp 11", i, {ram_en_a, ram_we_a}); end
      checks++; if (ram_addr_a !== AB'(i)) begin errors++; $display("FAIL fill_addr[%0d]: got %0d exp %0d", i, ram_addr_a, i); end
      checks++; if (ram_di_a !== W'(8'hA0 + i)) begin errors++; $display("FAIL fill_di[%0d]: got %h exp %h", i, ram_di_a, 8'hA0 + i); end
    end
    @(negedge clk); idle(); #1;
    checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL fill_rd_avail: got %b exp 1", rd_avail); end
    checks++; if (rd_len !== 4'd3) begin errors++; $display("FAIL fill_rd_len: got %0d exp 3", rd_len); end
    checks++; if (banks_full !== 2'd1) begin errors++; $display("FAIL fill_banks_full: got %0d exp 1", banks_full); end
    checks++; if (ram_addr_a !== 4'd8) begin errors++; $display("FAIL fill_next_bank: got %0d exp 8", ram_addr_a); end
    checks++; if (ram_en_a !== 1'b0) begin errors++; $display("FAIL fill_idle_en_a: got %b exp 0", ram_en_a); end
  endtask

  task automatic test_read();
    @(negedge clk); rd_req = 1; rd_addr = 3'd2; #1;
    checks++; if (ram_en_b !== 1'b1) begin errors++; $display("FAIL read_en_b: got %b exp 1", ram_en_b); end
    checks++; if (ram_addr_b !== 4'd2) begin errors++; $display("FAIL read_addr_b: got %0d exp 2", ram_addr_b); end
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %b exp 0", rd_data_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b exp 1", rd_data_valid); end
    checks++; if (rd_data !== 8'hA2) begin errors++; $display("FAIL read_data: got %h exp a2", rd_data); end
    checks++; if (ram_en_b !== 1'b0) begin errors++; $display("FAIL read_idle_en_b: got %b exp 0", ram_en_b); end
    @(negedge clk); #1;
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL read_valid_pulse: got %b exp 0", rd_data_valid); end
  endtask

  // Auto-commit at depth fills both banks; a further write must be refused.
  task automatic test_auto_commit();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr_valid = 1; wr_data = (i < 8) ? W'(8'hB0 + i) : W'(8'hC0 + i - 8); wr_last = 0; #1;
      checks++; if (ram_addr_a !== AB'(i) || ram_en_a !== 1'b1) begin errors++; $display("FAIL auto_addr[%0d]: got %0d en %b exp %0d en 1", i, ram_addr_a, ram_en_a, i); end
      if (i == 8) begin
        checks++; if (banks_full !== 2'd1 || rd_len !== 4'd8) begin errors++; $display("FAIL auto_bank0: got full %0d len %0d exp 1 8", banks_full, rd_len); end
      end
    end
    @(negedge clk); wr_valid = 1; wr_data = 8'hEE; #1;
    checks++; if (banks_full !== 2'd2) begin errors++; $display("FAIL auto_banks_full: got %0d exp 2", banks_full); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL auto_wr_ready: got %b exp 0", wr_ready); end
    checks++; if ({ram_en_a, ram_we_a} !== 2'b00) begin errors++; $display("FAIL auto_blocked_write: got %b exp 00", {ram_en_a, ram_we_a}); end
    wr_last = 1;
    @(negedge clk); idle(); #1;
    checks++; if (banks_full !== 2'd2 || rd_len !== 4'd8) begin errors++; $display("FAIL auto_blocked_state: got full %0d len %0d exp 2 8", banks_full, rd_len); end
  endtask

  // Continues from two full banks: read+release, then commit+release together.
  task automatic test_read_release();
    @(negedge clk); rd_req = 1; rd_addr = 3'd5; rd_done = 1; #1;
    checks++; if (ram_en_b !== 1'b1 || ram_addr_b !== 4'd5) begin errors++; $display("FAIL rr_access: got en %b addr %0d exp 1 5", ram_en_b, ram_addr_b); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data_valid !== 1'b1 || rd_data !== 8'hB5) begin errors++; $display("FAIL rr_data: got v %b d %h exp 1 b5", rd_data_valid, rd_data); end
    checks++; if (rd_avail !== 1'b1 || rd_len !== 4'd8) begin errors++; $display("FAIL rr_next_bank: got avail %b len %0d exp 1 8", rd_avail, rd_len); end
    checks++; if (wr_ready !== 1'b1 || banks_full !== 2'd1) begin errors++; $display("FAIL rr_freed: got ready %b full %0d exp 1 1", wr_ready, banks_full); end
    @(negedge clk); rd_req = 1; rd_addr = 3'd3; #1;
    checks++; if (ram_addr_b !== 4'd11) begin errors++; $display("FAIL rr_bank1_addr: got %0d exp 11", ram_addr_b); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL rr_bank1_data: got %h exp c3", rd_data); end
    @(negedge clk); wr_valid = 1; wr_data = 8'hD0; wr_last = 1; rd_done = 1; #1;
    checks++; if (ram_addr_a !== 4'd0 || ram_en_a !== 1'b1) begin errors++; $display("FAIL cr_write: got addr %0d en %b exp 0 1", ram_addr_a, ram_en_a); end
    @(negedge clk); idle(); #1;
    checks++; if (banks_full !== 2'd1 || rd_avail !== 1'b1 || rd_len !== 4'd1) begin errors++; $display("FAIL cr_state: got full %0d avail %b len %0d exp 1 1 1", banks_full, rd_avail, rd_len); end
    @(negedge clk); rd_done = 1;
    @(negedge clk); idle(); #1;
    checks++; if (banks_full !== 2'd0 || rd_avail !== 1'b0) begin errors++; $display("FAIL cr_drained: got full %0d avail %b exp 0 0", banks_full, rd_avail); end
  endtask

  // Read bank is 1 and write bank is 1 here; idle requests must not move either.
  task automatic test_idle_read();
    @(negedge clk); rd_req = 1; rd_done = 1; rd_addr = 3'd1; #1;
    checks++; if (ram_en_b !== 1'b0) begin errors++; $display("FAIL idle_en_b: got %b exp 0", ram_en_b); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data_valid !== 1'b0 || banks_full !== 2'd0 || rd_avail !== 1'b0) begin errors++; $display("FAIL idle_state: got v %b full %0d avail %b exp 0 0 0", rd_data_valid, banks_full, rd_avail); end
    wr_valid = 1; wr_data = 8'hE0; wr_last = 1; #1;
    checks++; if (ram_addr_a !== 4'd8) begin errors++; $display("FAIL idle_wb: got %0d exp 8", ram_addr_a); end
    @(negedge clk); idle(); rd_req = 1; rd_addr = 3'd0; #1;
    checks++; if (ram_addr_b !== 4'd8 || ram_en_b !== 1'b1) begin errors++; $display("FAIL idle_rb: got addr %0d en %b exp 8 1", ram_addr_b, ram_en_b); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data !== 8'hE0 || rd_data_valid !== 1'b1) begin errors++; $display("FAIL idle_data: got %h v %b exp e0 1", rd_data, rd_data_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_valid = 1; wr_data = W'(8'h50 + i); wr_last = (i == 2);
    end
    @(negedge clk); idle(); #1;
    checks++; if (banks_full !== 2'd1 || ram_addr_a !== 4'd10) begin errors++; $display("FAIL mid_pre: got full %0d addr %0d exp 1 10", banks_full, ram_addr_a); end
    rst = 1; rd_req = 1; rd_addr = 3'd0; #1;
    checks++; if (ram_en_b !== 1'b0) begin errors++; $display("FAIL mid_rst_en_b: got %b exp 0", ram_en_b); end
    @(negedge clk); rst = 0; idle(); #1;
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b exp 0", rd_data_valid); end
    checks++; if (wr_ready !== 1'b1 || rd_avail !== 1'b0 || banks_full !== 2'd0) begin errors++; $display("FAIL mid_state: got ready %b avail %b full %0d exp 1 0 0", wr_ready, rd_avail, banks_full); end
    wr_valid = 1; wr_data = 8'h77; #1;
    checks++; if (ram_addr_a !== 4'd0 || ram_en_a !== 1'b1) begin errors++; $display("FAIL mid_next_write: got addr %0d en %b exp 0 1", ram_addr_a, ram_en_a); end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_short_fill();
    test_read();
    test_auto_commit();
    test_read_release();
    test_idle_read();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
